// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//    UART transmitter fed by a small word FIFO. Words are queued through a
//    ready/valid style write port and sent one frame at a time:
//    start bit, DATA_BITS data bits LSB first, optional parity, stop bit(s).
//
// Parameters
//    CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//    DATA_BITS     data bits per frame (5..32)
//    PARITY_MODE   0 = none, 1 = even, 2 = odd
//    STOP_BITS     1 or 2
//    FIFO_DEPTH    queue entries, power of two, >= 2
//
// Ports
//    i_Clock       sole clock, rising edge
//    i_Reset       synchronous, active-high reset
//    i_Tx_DV       write request; accepted when i_Tx_DV && o_Tx_Ready
//    i_Tx_Data     word to queue, sampled on acceptance
//    o_Tx_Ready    FIFO not full (from the registered count only)
//    o_Fifo_Count  queued words, not counting the frame in flight
//    o_Tx_Active   high from START through STOP
//    o_Tx_Serial   registered serial line, idle high
//    o_Tx_Done     one-cycle pulse per completed frame
//
// FSM states
//    state     | meaning
//    S_IDLE    | line high; pops the FIFO head and starts a frame when non-empty
//    S_START   | start bit (line low)
//    S_DATA    | data bits, LSB first
//    S_PARITY  | parity bit (only when PARITY_MODE != 0)
//    S_STOP    | stop bit(s), line high
//    S_CLEANUP | one cycle, line high, o_Tx_Done asserted

module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic                          i_Tx_DV,
   input  logic [DATA_BITS-1:0]          i_Tx_Data,
   output logic                          o_Tx_Ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Done
);

   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;
   localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
   // One counter times every bit period, including the full stop span.
   localparam int CNT_W     = $clog2(STOP_CLKS);
   localparam int IDX_W     = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CLKS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
   localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic             HAS_PARITY = (PARITY_MODE != 0);
   localparam logic             PAR_INV    = (PARITY_MODE == 2);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 32) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..32");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_PARITY  = 3'd3,
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_t;

   state_t state, state_next;

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 wr_en, pop, fifo_empty;

   logic [CNT_W-1:0]     bit_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_bit;
   logic                 bit_tc, last_bit;

   logic                 serial_d, active_d, done_d;

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   assign fifo_empty   = (count == '0);
   assign o_Tx_Ready   = (count != FULL_COUNT);
   assign o_Fifo_Count = count;
   assign fifo_head    = fifo_mem[rd_ptr];
   assign wr_en        = i_Tx_DV && o_Tx_Ready;
   assign pop          = (state == S_IDLE) && !fifo_empty;

   always_ff @(posedge i_Clock) begin
      if (wr_en && !i_Reset) begin
         fifo_mem[wr_ptr] <= i_Tx_Data;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Bit timing and shift datapath
   // ------------------------------------------------------------------
   assign bit_tc   = (bit_cnt == '0);
   assign last_bit = (bit_idx == LAST_IDX);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  bit_cnt    <= BIT_LOAD;
                  bit_idx    <= '0;
                  shift_reg  <= fifo_head;
                  parity_bit <= (^fifo_head) ^ PAR_INV;
               end
            end
            S_START: begin
               if (bit_tc) begin
                  bit_cnt   <= BIT_LOAD;
                  shift_reg <= shift_reg >> 1;
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            S_DATA: begin
               if (bit_tc) begin
                  if (last_bit) begin
                     bit_cnt <= HAS_PARITY ? BIT_LOAD : STOP_LOAD;
                  end else begin
                     bit_cnt   <= BIT_LOAD;
                     bit_idx   <= bit_idx + IDX_W'(1);
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            S_PARITY: begin
               if (bit_tc) begin
                  bit_cnt <= STOP_LOAD;
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            S_STOP: begin
               if (bit_tc) begin
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt - CNT_W'(1);
               end
            end
            default: begin
               bit_cnt <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register (outputs are registered alongside the state)
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= S_IDLE;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
      end else begin
         state       <= state_next;
         o_Tx_Serial <= serial_d;
         o_Tx_Active <= active_d;
         o_Tx_Done   <= done_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (!fifo_empty) state_next = S_START;
         S_START:   if (bit_tc) state_next = S_DATA;
         S_DATA:    if (bit_tc && last_bit) state_next = HAS_PARITY ? S_PARITY : S_STOP;
         S_PARITY:  if (bit_tc) state_next = S_STOP;
         S_STOP:    if (bit_tc) state_next = S_CLEANUP;
         S_CLEANUP: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // FSM: outputs, computed as the value the output registers take at the
   // coming edge so the line changes exactly on the state transition.
   always_comb begin
      serial_d = o_Tx_Serial;
      active_d = o_Tx_Active;
      done_d   = 1'b0;
      case (state)
         S_IDLE: begin
            serial_d = !pop;
            active_d = pop;
         end
         S_START: begin
            if (bit_tc) serial_d = shift_reg[0];
         end
         S_DATA: begin
            if (bit_tc) begin
               if (last_bit) serial_d = HAS_PARITY ? parity_bit : 1'b1;
               else          serial_d = shift_reg[0];
            end
         end
         S_PARITY: begin
            if (bit_tc) serial_d = 1'b1;
         end
         S_STOP: begin
            if (bit_tc) begin
               serial_d = 1'b1;
               active_d = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: begin
            serial_d = 1'b1;
            active_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps

module tb_uart_tx_fifo;

   localparam int N_CFG = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_fin    = 0;

   task automatic chk(input string nm, input int inst,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cfg%0d t=%0t actual=%0h required=%0h", nm, inst, $time, act, exp);
      end
   endtask

   task automatic tmo(input string nm, input int inst);
      n_checks++;
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t actual=timeout required=event", nm, inst, $time);
   endtask

   for (genvar gi = 0; gi < N_CFG; gi++) begin : g_cfg
      localparam int C     = (gi == 4) ? 3 : 4;
      localparam int D     = (gi == 4) ? 5 : 8;
      localparam int P     = (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 4) ? 1 : 0;
      localparam int S     = (gi == 3 || gi == 4) ? 2 : 1;
      localparam int DEPTH = (gi == 4) ? 2 : 4;
      localparam int CW    = $clog2(DEPTH) + 1;
      localparam int NB    = 1 + D + ((P != 0) ? 1 : 0) + S;
      localparam int FRAME = NB * C;
      // Hand-derived frames, bit k of the pattern = k-th bit on the line.
      localparam logic [31:0] DIR_WORD = (gi == 0) ? 32'hA5 :
                                         (gi == 1) ? 32'h07 :
                                         (gi == 2) ? 32'h07 :
                                         (gi == 3) ? 32'h00 : 32'h16;
      localparam logic [11:0] DIR_PAT  = (gi == 0) ? 12'h34A :
                                         (gi == 1) ? 12'h60E :
                                         (gi == 2) ? 12'h40E :
                                         (gi == 3) ? 12'h600 : 12'h1EC;

      logic          rst  = 1'b1;
      logic          dv   = 1'b0;
      logic [D-1:0]  data = '0;
      logic          ser, act, dn, rdy;
      logic [CW-1:0] cnt;

      uart_tx_fifo #(
         .CLKS_PER_BIT (C),
         .DATA_BITS    (D),
         .PARITY_MODE  (P),
         .STOP_BITS    (S),
         .FIFO_DEPTH   (DEPTH)
      ) u_dut (
         .i_Clock      (clk),
         .i_Reset      (rst),
         .i_Tx_DV      (dv),
         .i_Tx_Data    (data),
         .o_Tx_Ready   (rdy),
         .o_Fifo_Count (cnt),
         .o_Tx_Active  (act),
         .o_Tx_Serial  (ser),
         .o_Tx_Done    (dn)
      );

      // Reference: a queue of pending words plus the frame in flight,
      // tracked as a cycle offset m_t from the edge that started it.
      logic [D-1:0] mq [$];
      logic [D-1:0] m_word  = '0;
      bit           m_busy  = 1'b0;
      bit           m_valid = 1'b0;
      int           m_t     = 0;

      function automatic logic fbit(input logic [D-1:0] w, input int k);
         logic par;
         if (k == 0) return 1'b0;
         if (k <= D) return w[k-1];
         if (P != 0 && k == D + 1) begin
            par = ^w;
            if (P == 2) par = ~par;
            return par;
         end
         return 1'b1;
      endfunction

      always @(posedge clk) begin
         bit acc;
         if (rst) begin
            mq.delete();
            m_busy  = 1'b0;
            m_t     = 0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            acc = dv && (mq.size() < DEPTH);
            if (m_busy) begin
               m_t++;
               // FRAME+0 is the done cycle, FRAME+1 the idle cycle
               if (m_t == FRAME + 1) m_busy = 1'b0;
            end else if (mq.size() > 0) begin
               m_word = mq.pop_front();
               m_busy = 1'b1;
               m_t    = 0;
            end
            if (acc) mq.push_back(data);
         end
      end

      always @(negedge clk) begin
         logic e_ser, e_act, e_done;
         if (m_valid) begin
            e_ser  = 1'b1;
            e_act  = 1'b0;
            e_done = 1'b0;
            if (m_busy) begin
               if (m_t < FRAME) begin
                  e_ser = fbit(m_word, m_t / C);
                  e_act = 1'b1;
               end else if (m_t == FRAME) begin
                  e_done = 1'b1;
               end
            end
            chk("serial", gi, 32'(ser), 32'(e_ser));
            chk("active", gi, 32'(act), 32'(e_act));
            chk("done",   gi, 32'(dn),  32'(e_done));
            chk("count",  gi, 32'(cnt), 32'(mq.size()));
            chk("ready",  gi, 32'(rdy), 32'(mq.size() < DEPTH));
         end
      end

      // Called at a negedge; returns at the negedge after the accepting edge.
      task automatic push(input logic [D-1:0] w);
         int n;
         n    = 0;
         dv   = 1'b1;
         data = w;
         while (!rdy && n < 1000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 1000) tmo("push_ready", gi);
         @(negedge clk);
      endtask

      task automatic wait_idle();
         int n;
         n = 0;
         while ((m_busy || mq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 3000) tmo("drain", gi);
      endtask

      initial begin
         logic [11:0] pat;
         int n;
         int dens;
         pat = DIR_PAT;

         rst = 1'b1;
         dv  = 1'b0;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         chk("rst_serial", gi, 32'(ser), 32'd1);
         chk("rst_active", gi, 32'(act), 32'd0);
         chk("rst_done",   gi, 32'(dn),  32'd0);
         chk("rst_count",  gi, 32'(cnt), 32'd0);
         chk("rst_ready",  gi, 32'(rdy), 32'd1);

         // single frame into an idle, empty transmitter
         push(D'(DIR_WORD));
         dv = 1'b0;
         for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            chk("dir_line", gi, 32'(ser), 32'(pat[k / C]));
         end
         @(negedge clk);
         chk("dir_done_pulse",  gi, 32'(dn),  32'd1);
         chk("dir_cleanup_act", gi, 32'(act), 32'd0);
         chk("dir_cleanup_ser", gi, 32'(ser), 32'd1);
         @(negedge clk);
         chk("dir_done_single", gi, 32'(dn),  32'd0);
         wait_idle();

         // held-valid burst that overruns the FIFO
         for (int j = 0; j < 6; j++) push(D'(32'h11 + j));
         dv = 1'b0;
         wait_idle();

         // reset in the middle of data bit 3 with two words queued
         push(D'(32'h21));
         push(D'(32'h22));
         push(D'(32'h23));
         dv = 1'b0;
         n  = 0;
         while (!(m_busy && m_t == 4 * C + 1) && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (n >= 500) tmo("reach_bit3", gi);
         chk("pre_reset_count", gi, 32'(cnt), 32'd2);
         rst  = 1'b1;
         dv   = 1'b1;
         data = D'(32'h33);
         @(negedge clk);
         rst = 1'b0;
         dv  = 1'b0;
         chk("abort_serial", gi, 32'(ser), 32'd1);
         chk("abort_active", gi, 32'(act), 32'd0);
         chk("abort_count",  gi, 32'(cnt), 32'd0);
         chk("abort_done",   gi, 32'(dn),  32'd0);
         chk("abort_ready",  gi, 32'(rdy), 32'd1);
         repeat (3 * C) @(negedge clk);
         push(D'(32'h5A));
         dv = 1'b0;
         wait_idle();

         // random traffic with varying write density and rare resets
         dens = 4;
         for (int r = 0; r < 1500; r++) begin
            if (r % 100 == 0) dens = $urandom_range(1, 8);
            rst  = ($urandom_range(0, 499) == 0);
            dv   = ($urandom_range(0, 7) < dens);
            data = D'($urandom);
            @(negedge clk);
         end
         rst = 1'b0;
         dv  = 1'b0;
         wait_idle();
         repeat (2) @(negedge clk);
         n_fin++;
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      while (n_fin < N_CFG && cyc < 30000) begin
         @(posedge clk);
         cyc++;
      end
      if (n_fin < N_CFG) tmo("global", -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87: clock cycles per UART bit, legal range >= 2.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..32.
REQ-003 Parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd; any other value SHALL be an elaboration error.
REQ-004 Parameter STOP_BITS, default 1: stop-bit count, legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, >= 2.
REQ-006 i_Clock  in  1  sole clock; all logic on its rising edge.
REQ-007 i_Reset  in  1  reset, synchronous, active-high.
REQ-008 i_Tx_DV  in  1  write request; word accepted when i_Tx_DV && o_Tx_Ready at a rising edge.
REQ-009 i_Tx_Data  in  DATA_BITS  word to transmit, sampled on acceptance.
REQ-010 o_Tx_Ready  out  1  high when the FIFO is not full.
REQ-011 o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  number of queued words, excluding the frame in flight.
REQ-012 o_Tx_Active  out  1  high while a frame occupies START through STOP.
REQ-013 o_Tx_Serial  out  1  registered serial line; idle high.
REQ-014 o_Tx_Done  out  1  one-cycle pulse per completed frame.

Function
REQ-015 FIFO SHALL be first-in first-out with no loss or duplication; a write and a pop in the same cycle leave o_Fifo_Count unchanged.
REQ-016 o_Tx_Ready SHALL depend only on the registered count; when full, a write is refused even if a pop occurs in the same cycle.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP, CLEANUP.
REQ-018 IDLE: line high; if the FIFO is non-empty, pop the head into the shift register and enter START at the same edge; o_Tx_Serial goes low and o_Tx_Active goes high at that edge.
REQ-019 A word accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive o_Tx_Serial low at edge N+1.
REQ-020 START: line 0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: bits sent LSB first, each held exactly CLKS_PER_BIT cycles; after bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else STOP.
REQ-022 PARITY: bit = XOR of all data bits (even) or its inverse (odd), held CLKS_PER_BIT cycles, then STOP.
REQ-023 STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles, then CLEANUP; o_Tx_Active deasserts on entry to CLEANUP.
REQ-024 CLEANUP: line 1 and o_Tx_Done high for exactly this one cycle, then IDLE.
REQ-025 Back-to-back frames: the inter-frame idle-high gap SHALL be exactly 2 cycles (CLEANUP + IDLE) beyond the stop bits.
REQ-026 The bit-period counter SHALL be sized $clog2(CLKS_PER_BIT) bits minimum and never wrap within a bit; the bit index SHALL be sized to reach DATA_BITS-1.
REQ-027 Writes remain accepted during an active frame; FIFO contents are unaffected by FSM state.
REQ-028 Unreachable state encodings SHALL return to IDLE with the line high.

Reset
REQ-029 While i_Reset is high at an edge: FSM to IDLE, FIFO emptied, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, counters 0.
REQ-030 Reset mid-frame SHALL abort the frame at the next edge without a o_Tx_Done pulse; writes presented during reset are ignored.

Verification (bench: CLKS_PER_BIT=4 unless stated)
REQ-031 DATA_BITS=8, no parity, STOP_BITS=1; write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, 4 cycles each; o_Tx_Done single pulse the cycle after the 40th line cycle.
REQ-032 PARITY_MODE=1, write 0x07 -> parity bit 1; PARITY_MODE=2, same word -> parity bit 0; frame length 44 cycles.
REQ-033 STOP_BITS=2, write 0x00 -> stop high 8 cycles, then o_Tx_Done pulse; o_Tx_Active low from the CLEANUP cycle.
REQ-034 FIFO_DEPTH=4; hold i_Tx_DV with words 0x11..0x16, advancing only on handshake -> o_Tx_Ready low whenever count=4; all six transmitted in order with 2-cycle gaps.
REQ-035 Assert i_Tx_Reset... i.e. i_Reset one cycle during data bit 3 with 2 words queued -> next edge line 1, o_Tx_Active 0, count 0, no done pulse; a later write of 0x5A transmits correctly.
